wordle_round_ctrl: RTL and testbench
====================================

WORDLE_ROUND_CTRL -- requirements
Module: wordle_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_ATTEMPTS, default 6, guesses allowed per round (1..7).
REQ-002 SHALL have parameter NUM_WORDS, default 20, word-bank entries (2..32).
REQ-003 SHALL have parameter FLASH_DIV, default 22, clk cycles per flash toggle in WIN.
REQ-004 SHALL have port clk  in  1  single clock; all flops rise-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high.
REQ-006 SHALL have port enter  in  1  raw active-low pushbutton, asynchronous to clk.
REQ-007 SHALL have port letter_valid  in  1  switch pattern decodes to a legal letter.
REQ-008 SHALL have port match  in  4  per-slot guess==word flags from the datapath comparator, bit0=slot 0.
REQ-009 SHALL have port word_idx  out  5  word-bank select index.
REQ-010 SHALL have port word_load  out  1  one-cycle pulse: latch bank word word_idx.
REQ-011 SHALL have port slot_wr  out  1  one-cycle pulse: store current letter into slot slot_idx.
REQ-012 SHALL have port slot_idx  out  2  active letter slot 0..3.
REQ-013 SHALL have port disp_mode  out  3  display select: IDLE, ENTRY, RESULT, WIN, LOSE.
REQ-014 SHALL have port attempts  out  3  guesses consumed this round.
REQ-015 SHALL have ports match_led  out  4  registered match of last guess; bad_letter  out  1  one-cycle pulse on rejected entry; win  out  1  level; lose  out  1  level; flash  out  1  celebration blink.

Function
REQ-016 SHALL pass enter through a 2-flop synchronizer and generate press as a one-cycle pulse on each synchronized 1->0 transition; a held button yields exactly one press.
REQ-017 SHALL implement states IDLE, ENTRY, CHECK, RESULT, WIN, LOSE; disp_mode equals the state encoding, with CHECK displayed as ENTRY.
REQ-018 SHALL, in IDLE, advance word_idx by 1 each cycle, wrapping from NUM_WORDS-1 to 0.
REQ-019 SHALL hold word_idx constant in every state other than IDLE.
REQ-020 SHALL, on press in IDLE, pulse word_load with the current word_idx, set slot_idx=0, and enter ENTRY on the next cycle.
REQ-021 SHALL, on press in ENTRY with letter_valid=1, pulse slot_wr in the same cycle as press; slot_idx then increments, or the FSM moves to CHECK when slot_idx==3.
REQ-022 SHALL, on press in ENTRY with letter_valid=0, pulse bad_letter, leave slot_idx unchanged and issue no slot_wr.
REQ-023 SHALL spend exactly one cycle in CHECK, in which it registers match into match_led and increments attempts.
REQ-024 SHALL leave CHECK to WIN if match==4'b1111, else to LOSE if the new attempts value equals MAX_ATTEMPTS, else to RESULT; WIN has priority over LOSE on the last attempt.
REQ-025 SHALL, on press in RESULT, set slot_idx=0 and enter ENTRY; match_led holds until the next CHECK.
REQ-026 SHALL, on press in WIN or LOSE, clear attempts and match_led and enter IDLE.
REQ-027 SHALL ignore a press that occurs in CHECK.
REQ-028 SHALL assert win only in WIN and lose only in LOSE.
REQ-029 SHALL, in WIN, toggle flash every FLASH_DIV cycles, starting at 0 on WIN entry; flash SHALL be 0 in all other states.
REQ-030 SHALL saturate attempts at MAX_ATTEMPTS, and all pulse outputs SHALL be registered and last exactly one cycle.

Reset
REQ-031 SHALL, on reset, asynchronously force: state=IDLE, word_idx=0, slot_idx=0, attempts=0, match_led=0, all pulses=0, win=lose=flash=0, synchronizer flops=1 (released button).
REQ-032 SHALL discard a press that coincides with reset or a partially entered guess, with no word_load or slot_wr issued.

Structure
REQ-033 SHALL take the state/disp_mode enum, the letter-slot count (4) and the default constants from shared package wordle_pkg.
REQ-034 SHALL contain one sub-module, btn_edge: synchronizer plus falling-edge detector, reused for any future button.

Verification
REQ-035 SHALL cover: reset, idle 7 cycles, press -> word_load pulse with word_idx=7, disp_mode=ENTRY, slot_idx=0.
REQ-036 SHALL cover: 4 valid presses, match=4'b1111 -> 4 slot_wr pulses at slot_idx 0,1,2,3, attempts=1, win=1, flash toggling every 22 cycles.
REQ-037 SHALL cover: 6 guesses with match=4'b0101 -> match_led=4'b0101 after each, RESULT 5 times, then lose=1 with attempts=6.
REQ-038 SHALL cover: 6th guess with match=4'b1111 -> win=1, lose=0.
REQ-039 SHALL cover: press with letter_valid=0 in slot 2 -> bad_letter pulse, no slot_wr, slot_idx stays 2; button held low for 50 cycles -> exactly one press.
REQ-040 SHALL cover: reset asserted mid-entry at slot 3 -> all outputs at reset values immediately, IDLE after release.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared types and defaults for the word-guessing round controller.
package wordle_pkg;
  localparam int NUM_SLOTS        = 4;
  localparam int DEF_MAX_ATTEMPTS = 6;
  localparam int DEF_NUM_WORDS    = 20;
  localparam int DEF_FLASH_DIV    = 22;

  // Encoding doubles as the display select; CHECK is never shown as itself.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_RESULT = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4,
    ST_CHECK  = 3'd5
  } state_t;

  function automatic logic [2:0] disp_of(state_t s);
    return (s == ST_CHECK) ? 3'(ST_ENTRY) : 3'(s);
  endfunction
endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer on an active-low button plus falling-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  // [0] metastable, [1] synchronized, [2] previous synchronized value
  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '1;
    else     sync <= {sync[1:0], btn_n};

  assign press = sync[2] & ~sync[1];
endmodule

// File: rtl/wordle_round_ctrl.sv
// Round controller: word pick, letter entry, guess scoring, win/lose display.
module wordle_round_ctrl
  import wordle_pkg::*;
#(
  parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int FLASH_DIV    = DEF_FLASH_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       letter_valid,
  input  logic [3:0] match,
  output logic [4:0] word_idx,
  output logic       word_load,
  output logic       slot_wr,
  output logic [1:0] slot_idx,
  output logic [2:0] disp_mode,
  output logic [2:0] attempts,
  output logic [3:0] match_led,
  output logic       bad_letter,
  output logic       win,
  output logic       lose,
  output logic       flash
);
  localparam int FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [1:0] LAST_SLOT = 2'(NUM_SLOTS - 1);

  state_t         state;
  logic           press;
  logic [FCW-1:0] flash_cnt;
  logic [2:0]     att_nxt;

  btn_edge u_enter (.clk(clk), .rst(reset), .btn_n(enter), .press(press));

  assign att_nxt = (attempts == 3'(MAX_ATTEMPTS)) ? attempts : attempts + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      disp_mode  <= disp_of(ST_IDLE);
      word_idx   <= '0;
      slot_idx   <= '0;
      attempts   <= '0;
      match_led  <= '0;
      word_load  <= 1'b0;
      slot_wr    <= 1'b0;
      bad_letter <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      flash      <= 1'b0;
      flash_cnt  <= '0;
    end else begin
      word_load  <= 1'b0;
      slot_wr    <= 1'b0;
      bad_letter <= 1'b0;
      case (state)
        ST_IDLE:
          if (press) begin
            word_load <= 1'b1;
            slot_idx  <= '0;
            state     <= ST_ENTRY;
            disp_mode <= disp_of(ST_ENTRY);
          end else begin
            word_idx <= (word_idx == 5'(NUM_WORDS - 1)) ? '0 : word_idx + 5'd1;
          end
        ST_ENTRY:
          // slot_wr is shown alongside the slot it writes; the index moves on
          // in the cycle the pulse is visible.
          if (slot_wr) begin
            if (slot_idx == LAST_SLOT) begin
              state     <= ST_CHECK;
              disp_mode <= disp_of(ST_CHECK);
            end else begin
              slot_idx <= slot_idx + 2'd1;
            end
          end else if (press) begin
            if (letter_valid) slot_wr    <= 1'b1;
            else              bad_letter <= 1'b1;
          end
        ST_CHECK: begin
          match_led <= match;
          attempts  <= att_nxt;
          if (match == 4'b1111) begin
            state     <= ST_WIN;
            disp_mode <= disp_of(ST_WIN);
            win       <= 1'b1;
            flash     <= 1'b0;
            flash_cnt <= '0;
          end else if (att_nxt == 3'(MAX_ATTEMPTS)) begin
            state     <= ST_LOSE;
            disp_mode <= disp_of(ST_LOSE);
            lose      <= 1'b1;
          end else begin
            state     <= ST_RESULT;
            disp_mode <= disp_of(ST_RESULT);
          end
        end
        ST_RESULT:
          if (press) begin
            slot_idx  <= '0;
            state     <= ST_ENTRY;
            disp_mode <= disp_of(ST_ENTRY);
          end
        ST_WIN, ST_LOSE:
          if (press) begin
            attempts  <= '0;
            match_led <= '0;
            win       <= 1'b0;
            lose      <= 1'b0;
            flash     <= 1'b0;
            state     <= ST_IDLE;
            disp_mode <= disp_of(ST_IDLE);
          end else if (state == ST_WIN) begin
            if (flash_cnt == FCW'(FLASH_DIV - 1)) begin
              flash_cnt <= '0;
              flash     <= ~flash;
            end else begin
              flash_cnt <= flash_cnt + FCW'(1);
            end
          end
        default: begin
          state     <= ST_IDLE;
          disp_mode <= disp_of(ST_IDLE);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wordle_round_ctrl.sv
// Bench for wordle_round_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_wordle_round_ctrl;
  localparam int MAXA = 6, NW = 20, FD = 22;
  localparam int S_IDLE = 0, S_ENTRY = 1, S_RESULT = 2, S_WIN = 3, S_LOSE = 4, S_CHECK = 5;

  logic clk = 1'b0, reset = 1'b1, enter = 1'b1, letter_valid = 1'b1;
  logic [3:0] match = 4'd0;
  logic [4:0] word_idx;
  logic       word_load, slot_wr, bad_letter, win, lose, flash;
  logic [1:0] slot_idx;
  logic [2:0] disp_mode, attempts;
  logic [3:0] match_led;

  wordle_round_ctrl #(.MAX_ATTEMPTS(MAXA), .NUM_WORDS(NW), .FLASH_DIV(FD)) dut (
    .clk(clk), .reset(reset), .enter(enter), .letter_valid(letter_valid), .match(match),
    .word_idx(word_idx), .word_load(word_load), .slot_wr(slot_wr), .slot_idx(slot_idx),
    .disp_mode(disp_mode), .attempts(attempts), .match_led(match_led),
    .bad_letter(bad_letter), .win(win), .lose(lose), .flash(flash));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: press is seen when the button sample from three edges
  // back was high and the one from two edges back was low.
  int m_st = S_IDLE, m_widx = 0, m_sidx = 0, m_att = 0, m_mled = 0, m_fn = 0;
  bit m_wl = 0, m_sw = 0, m_bl = 0;
  bit [2:0] m_h = 3'b111;

  always @(posedge clk or posedge reset) begin : model
    bit pr, commit;
    if (reset) begin
      m_st = S_IDLE; m_widx = 0; m_sidx = 0; m_att = 0; m_mled = 0; m_fn = 0;
      m_wl = 0; m_sw = 0; m_bl = 0; m_h = 3'b111;
    end else begin
      pr = m_h[2] & ~m_h[1];
      m_h = {m_h[1:0], enter};
      commit = m_sw;
      m_wl = 0; m_sw = 0; m_bl = 0;
      case (m_st)
        S_IDLE:
          if (pr) begin m_wl = 1; m_sidx = 0; m_st = S_ENTRY; end
          else m_widx = (m_widx + 1) % NW;
        S_ENTRY:
          if (commit) begin
            if (m_sidx == 3) m_st = S_CHECK; else m_sidx++;
          end else if (pr) begin
            if (letter_valid) m_sw = 1; else m_bl = 1;
          end
        S_CHECK: begin
          m_mled = match;
          if (m_att < MAXA) m_att++;
          if (match == 4'hF) begin m_st = S_WIN; m_fn = 0; end
          else if (m_att == MAXA) m_st = S_LOSE;
          else m_st = S_RESULT;
        end
        S_RESULT:
          if (pr) begin m_sidx = 0; m_st = S_ENTRY; end
        default:
          if (pr) begin m_st = S_IDLE; m_att = 0; m_mled = 0; end
          else m_fn++;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("word_idx",   word_idx,   m_widx);
      chk("word_load",  word_load,  m_wl);
      chk("slot_wr",    slot_wr,    m_sw);
      chk("slot_idx",   slot_idx,   m_sidx);
      chk("bad_letter", bad_letter, m_bl);
      chk("disp_mode",  disp_mode,  (m_st == S_CHECK) ? S_ENTRY : m_st);
      chk("attempts",   attempts,   m_att);
      chk("match_led",  match_led,  m_mled);
      chk("win",        win,        m_st == S_WIN);
      chk("lose",       lose,       m_st == S_LOSE);
      chk("flash",      flash,      (m_st == S_WIN) ? (m_fn / FD) % 2 : 0);
    end
  end

  // Event log used by the directed checks.
  int cyc = 0, wl_cnt = 0, sw_cnt = 0, bl_cnt = 0, win_start = 0;
  int sw_q[$], fl_q[$];
  logic win_d = 0, flash_d = 0;
  always @(negedge clk) begin
    if (started && !reset) begin
      cyc++;
      if (word_load) wl_cnt++;
      if (slot_wr) begin sw_cnt++; sw_q.push_back(int'(slot_idx)); end
      if (bad_letter) bl_cnt++;
      if (win && !win_d) win_start = cyc;
      if (flash != flash_d) fl_q.push_back(cyc);
      win_d = win; flash_d = flash;
    end
  end

  task automatic press_btn(input logic lv, input int hold);
    letter_valid = lv;
    enter = 1'b0;
    repeat (hold) @(negedge clk);
    enter = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic guess(input logic [3:0] m);
    match = m;
    repeat (4) press_btn(1'b1, 3);
  endtask

  initial begin
    int s, b, w;
    repeat (2) @(negedge clk);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_disp", disp_mode, S_IDLE);
    chk("rst_attempts", attempts, 0);
    chk("rst_win_lose_flash", {win, lose, flash}, 0);
    @(negedge clk);
    reset = 1'b0;
    started = 1'b1;

    // Button drops after 5 idle edges; word_load appears 3 edges later at index 7.
    repeat (5) @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_word_load", word_load, 1);
    chk("start_word_idx", word_idx, 7);
    chk("start_disp", disp_mode, S_ENTRY);
    chk("start_slot_idx", slot_idx, 0);
    enter = 1'b1;
    repeat (4) @(negedge clk);

    // First-guess win and flash cadence
    sw_q.delete();
    fl_q.delete();
    guess(4'hF);
    repeat (50) @(negedge clk);
    chk("win_sw_count", sw_q.size(), 4);
    for (int i = 0; i < 4 && i < sw_q.size(); i++) chk("win_sw_slot", sw_q[i], i);
    chk("win_attempts", attempts, 1);
    chk("win_level", win, 1);
    chk("win_flash_edges", fl_q.size() >= 2, 1);
    if (fl_q.size() >= 2) begin
      chk("flash_first_toggle", fl_q[0] - win_start, FD);
      chk("flash_second_toggle", fl_q[1] - fl_q[0], FD);
    end
    press_btn(1'b1, 3);
    chk("back_idle_disp", disp_mode, S_IDLE);
    chk("back_idle_attempts", attempts, 0);
    chk("back_idle_match_led", match_led, 0);

    // Six misses -> lose
    press_btn(1'b1, 3);
    for (int g = 1; g <= 6; g++) begin
      guess(4'b0101);
      chk("miss_match_led", match_led, 4'b0101);
      chk("miss_attempts", attempts, g);
      if (g < 6) begin
        chk("miss_result_disp", disp_mode, S_RESULT);
        press_btn(1'b1, 3);
      end else begin
        chk("lose_level", lose, 1);
        chk("lose_win_low", win, 0);
        chk("lose_disp", disp_mode, S_LOSE);
      end
    end

    // Win on the final attempt beats lose
    press_btn(1'b1, 3);
    press_btn(1'b1, 3);
    for (int g = 1; g <= 5; g++) begin
      guess(4'b0101);
      press_btn(1'b1, 3);
    end
    guess(4'hF);
    chk("last_win", win, 1);
    chk("last_lose", lose, 0);
    chk("last_attempts", attempts, MAXA);
    press_btn(1'b1, 3);

    // Rejected letter and long hold
    press_btn(1'b1, 3);
    press_btn(1'b1, 3);
    press_btn(1'b1, 3);
    chk("bad_pre_slot", slot_idx, 2);
    s = sw_cnt; b = bl_cnt;
    press_btn(1'b0, 3);
    chk("bad_pulse", bl_cnt, b + 1);
    chk("bad_no_wr", sw_cnt, s);
    chk("bad_slot_hold", slot_idx, 2);
    press_btn(1'b1, 50);
    chk("hold_one_wr", sw_cnt, s + 1);
    chk("hold_slot", slot_idx, 3);

    // Reset mid-entry, with a press that begins and ends inside reset
    @(posedge clk);
    #2 reset = 1'b1;
    enter = 1'b0;
    #1;
    chk("mid_rst_outputs",
        {word_idx, word_load, slot_wr, slot_idx, attempts, match_led, bad_letter, win, lose, flash}, 0);
    chk("mid_rst_disp", disp_mode, S_IDLE);
    #1 enter = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    w = wl_cnt; s = sw_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_no_load", wl_cnt, w);
    chk("post_rst_no_wr", sw_cnt, s);
    chk("post_rst_disp", disp_mode, S_IDLE);
    chk("post_rst_word_idx", word_idx, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
